// File: rtl/mcu_csr_file.sv
// Machine-mode CSR file for a small MCU core: trap/MRET state, external and
// watchdog interrupt, watchdog down-counter, mailbox status and ID registers.
module mcu_csr_file #(
   parameter logic [31:0] UID_VAL  = 32'h0000_0001,
   parameter logic [31:0] CAPS_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_valid,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        csr_src_zero,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   input  logic        irq_ext,
   input  logic        mbox_event,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        irq_take,
   output logic        wdog_expired
);

   typedef enum logic [1:0] {OP_NONE = 2'd0, OP_W = 2'd1, OP_S = 2'd2, OP_C = 2'd3} csr_op_e;

   logic        mst_mie, mst_mpie, mie_meie, meip_q;
   logic [29:0] mtvec_q, mepc_q;
   logic [31:0] mscratch_q, mcause_q, mtval_q, mbox_base_q, trace_ctrl_q;
   logic [31:0] wdog_cnt;
   logic        wdog_en, wdog_exp, mbox_st;

   logic        hit, ro, access, write_try, wr_en;
   logic [31:0] rd_val, wval;

   always_comb begin
      rd_val = '0;
      hit    = 1'b1;
      ro     = 1'b0;
      case (csr_addr)
         12'h300: rd_val = {24'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
         12'h304: rd_val = {20'b0, mie_meie, 11'b0};
         12'h305: rd_val = {mtvec_q, 2'b00};
         12'h340: rd_val = mscratch_q;
         12'h341: rd_val = {mepc_q, 2'b00};
         12'h342: rd_val = mcause_q;
         12'h343: rd_val = mtval_q;
         12'h344: begin rd_val = {20'b0, meip_q, 3'b0, wdog_exp, 7'b0}; ro = 1'b1; end
         12'h7C0: begin rd_val = UID_VAL;  ro = 1'b1; end
         12'h7C1: begin rd_val = CAPS_VAL; ro = 1'b1; end
         12'h7C2: rd_val = wdog_cnt;
         12'h7C3: rd_val = {31'b0, wdog_en};
         12'h7C4: rd_val = mbox_base_q;
         12'h7C5: rd_val = {31'b0, mbox_st};
         12'h7C6: rd_val = trace_ctrl_q;
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      wval = csr_wdata;
      case (csr_op)
         OP_S:    wval = rd_val | csr_wdata;
         OP_C:    wval = rd_val & ~csr_wdata;
         default: wval = csr_wdata;
      endcase
   end

   assign access      = csr_valid & (csr_op != OP_NONE);
   assign write_try   = (csr_op == OP_W) | (((csr_op == OP_S) | (csr_op == OP_C)) & ~csr_src_zero);
   assign csr_illegal = access & (~hit | (ro & write_try));
   assign csr_rdata   = rd_val;
   // Trap and MRET pre-empt every CSR write in the same cycle.
   assign wr_en       = access & ~csr_illegal & write_try & ~trap_valid & ~mret;

   assign mtvec_o      = {mtvec_q, 2'b00};
   assign mepc_o       = {mepc_q, 2'b00};
   assign wdog_expired = wdog_exp;
   assign irq_take     = mst_mie & mie_meie & (meip_q | wdog_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_mie      <= 1'b0;
         mst_mpie     <= 1'b0;
         mie_meie     <= 1'b0;
         meip_q       <= 1'b0;
         mtvec_q      <= '0;
         mepc_q       <= '0;
         mscratch_q   <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
         mbox_base_q  <= '0;
         trace_ctrl_q <= '0;
      end else begin
         meip_q <= irq_ext;
         if (trap_valid) begin
            mepc_q   <= trap_pc[31:2];
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
         end else if (mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (wr_en) begin
            case (csr_addr)
               12'h300: begin mst_mie <= wval[3]; mst_mpie <= wval[7]; end
               12'h304: mie_meie     <= wval[11];
               12'h305: mtvec_q      <= wval[31:2];
               12'h340: mscratch_q   <= wval;
               12'h341: mepc_q       <= wval[31:2];
               12'h342: mcause_q     <= wval;
               12'h343: mtval_q      <= wval;
               12'h7C4: mbox_base_q  <= wval;
               12'h7C6: trace_ctrl_q <= wval;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         wdog_en  <= 1'b0;
         wdog_exp <= 1'b0;
      end else begin
         if (wr_en && csr_addr == 12'h7C2) begin
            wdog_cnt <= wval;
            wdog_exp <= 1'b0;
         end else if (wdog_en && wdog_cnt != '0) begin
            wdog_cnt <= wdog_cnt - 32'd1;
            if (wdog_cnt == 32'd1) wdog_exp <= 1'b1;
         end
         if (wr_en && csr_addr == 12'h7C3) begin
            wdog_en <= wval[0];
            if (!wval[0]) wdog_exp <= 1'b0;
         end
      end
   end

   // Clear keys off the raw operand bit so any op with bit 0 set clears; a new event wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mbox_st <= 1'b0;
      else        mbox_st <= mbox_event | (mbox_st & ~(wr_en && csr_addr == 12'h7C5 && csr_wdata[0]));
   end

endmodule

// File: tb/tb_mcu_csr_file.sv
// Directed bench for mcu_csr_file: vector table for CSR access semantics plus
// hand sequences for trap/MRET, interrupts, watchdog, mailbox and reset.
module tb_mcu_csr_file;

   localparam logic [31:0] UID  = 32'hCAFE_0001;
   localparam logic [31:0] CAPS = 32'h0000_00A5;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        csr_valid = 1'b0, csr_src_zero = 1'b0;
   logic [1:0]  csr_op = 2'd0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0, csr_rdata;
   logic        csr_illegal;
   logic        trap_valid = 1'b0, mret = 1'b0, irq_ext = 1'b0, mbox_event = 1'b0;
   logic [31:0] trap_pc = '0, trap_cause = '0, trap_tval = '0;
   logic [31:0] mtvec_o, mepc_o;
   logic        irq_take, wdog_expired;

   int unsigned total = 0, bad = 0;

   mcu_csr_file #(.UID_VAL(UID), .CAPS_VAL(CAPS)) dut (
      .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
      .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
      .mret(mret), .irq_ext(irq_ext), .mbox_event(mbox_event), .mtvec_o(mtvec_o),
      .mepc_o(mepc_o), .irq_take(irq_take), .wdog_expired(wdog_expired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        valid;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        sz;
      logic [31:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [1:0] op, logic [11:0] a, logic [31:0] wd,
                               logic sz, logic [31:0] rd, logic ill);
      vec_t t;
      t.valid = v; t.op = op; t.addr = a; t.wdata = wd; t.sz = sz;
      t.exp_rd = rd; t.exp_ill = ill;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic sz);
      csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd; csr_src_zero = sz;
   endtask

   task automatic clr_csr();
      csr_valid = 1'b0; csr_op = 2'd0; csr_wdata = '0; csr_src_zero = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] wd);
      set_csr(2'd1, a, wd, 1'b0);
      tick();
      clr_csr();
   endtask

   // Pure read (CSRS with zero source): no state change, no clock edge needed.
   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      set_csr(2'd2, a, 32'h0, 1'b1);
      #1;
      check(name, csr_rdata, exp);
      clr_csr();
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_illegal", {31'b0, csr_illegal}, 32'h0);
      check("rst_irq_take", {31'b0, irq_take}, 32'h0);
      check("rst_wdog_exp", {31'b0, wdog_expired}, 32'h0);
      check("rst_mtvec", mtvec_o, 32'h0);
      check("rst_mepc", mepc_o, 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      vecs.push_back(mk(1, 2'd1, 12'h305, 32'h8000_0103, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd2, 12'h305, 32'h0,         1, 32'h8000_0100, 0));
      vecs.push_back(mk(1, 2'd1, 12'h340, 32'hDEAD_BEEF, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd2, 12'h340, 32'h0000_0010, 0, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(1, 2'd3, 12'h340, 32'h0000_000F, 0, 32'hDEAD_BEFF, 0));
      vecs.push_back(mk(1, 2'd2, 12'h340, 32'h0,         1, 32'hDEAD_BEF0, 0));
      vecs.push_back(mk(1, 2'd1, 12'h300, 32'hFFFF_FFFF, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd3, 12'h300, 32'h0000_0008, 0, 32'h0000_0088, 0));
      vecs.push_back(mk(1, 2'd2, 12'h300, 32'h0,         1, 32'h0000_0080, 0));
      vecs.push_back(mk(1, 2'd1, 12'h7C0, 32'h0000_0005, 0, UID,           1));
      vecs.push_back(mk(1, 2'd2, 12'h7C0, 32'h0,         1, UID,           0));
      vecs.push_back(mk(1, 2'd1, 12'h123, 32'hFFFF_FFFF, 0, 32'h0,         1));
      vecs.push_back(mk(1, 2'd2, 12'h7C1, 32'h0,         1, CAPS,          0));
      vecs.push_back(mk(1, 2'd2, 12'h344, 32'h0000_0001, 0, 32'h0,         1));
      vecs.push_back(mk(1, 2'd3, 12'h344, 32'h0,         1, 32'h0,         0));
      vecs.push_back(mk(1, 2'd1, 12'h341, 32'h0000_1237, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd2, 12'h341, 32'h0,         1, 32'h0000_1234, 0));
      vecs.push_back(mk(1, 2'd1, 12'h304, 32'hFFFF_FFFF, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd2, 12'h304, 32'h0,         1, 32'h0000_0800, 0));
      vecs.push_back(mk(1, 2'd1, 12'h7C6, 32'hA5A5_A5A5, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd3, 12'h7C6, 32'h0,         1, 32'hA5A5_A5A5, 0));
      vecs.push_back(mk(1, 2'd1, 12'h7C3, 32'hFFFF_FFFE, 0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd2, 12'h7C3, 32'h0,         1, 32'h0,         0));
      vecs.push_back(mk(0, 2'd1, 12'h123, 32'h0,         0, 32'h0,         0));
      vecs.push_back(mk(1, 2'd0, 12'h123, 32'h0,         0, 32'h0,         0));

      foreach (vecs[i]) begin
         csr_valid = vecs[i].valid; csr_op = vecs[i].op; csr_addr = vecs[i].addr;
         csr_wdata = vecs[i].wdata; csr_src_zero = vecs[i].sz;
         #1;
         check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].exp_ill});
         tick();
      end
      clr_csr();
      check("mtvec_o", mtvec_o, 32'h8000_0100);
      check("mepc_o_masked", mepc_o, 32'h0000_1234);

      // External interrupt, trap entry, MRET
      wr(12'h300, 32'h0000_0008);
      irq_ext = 1'b1;
      #1;
      check("irq_take_sync_delay", {31'b0, irq_take}, 32'h0);
      tick();
      check("irq_take_high", {31'b0, irq_take}, 32'h1);
      trap_valid = 1'b1; trap_pc = 32'h0000_1004; trap_cause = 32'h8000_000B; trap_tval = 32'h55;
      tick();
      trap_valid = 1'b0;
      check("trap_mepc", mepc_o, 32'h0000_1004);
      rd("trap_mstatus", 12'h300, 32'h0000_0080);
      rd("trap_mcause", 12'h342, 32'h8000_000B);
      rd("trap_mtval", 12'h343, 32'h0000_0055);
      rd("trap_mip", 12'h344, 32'h0000_0800);
      check("trap_irq_masked", {31'b0, irq_take}, 32'h0);
      mret = 1'b1;
      tick();
      mret = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h0000_0088);
      check("mret_irq_take", {31'b0, irq_take}, 32'h1);
      irq_ext = 1'b0;
      tick();
      check("irq_drop", {31'b0, irq_take}, 32'h0);

      // Same-cycle priority: trap over CSR write, mret over CSR write
      set_csr(2'd1, 12'h300, 32'h0000_0008, 1'b0);
      trap_valid = 1'b1; trap_pc = 32'h0000_2002;
      tick();
      trap_valid = 1'b0; clr_csr();
      rd("prio_trap_mstatus", 12'h300, 32'h0000_0080);
      check("prio_trap_mepc", mepc_o, 32'h0000_2000);
      set_csr(2'd3, 12'h300, 32'h0000_0088, 1'b0);
      mret = 1'b1;
      tick();
      mret = 1'b0; clr_csr();
      rd("prio_mret_mstatus", 12'h300, 32'h0000_0088);

      // Watchdog countdown, sticky expiry, reload, freeze
      wr(12'h7C2, 32'd3);
      wr(12'h7C3, 32'd1);
      set_csr(2'd2, 12'h7C2, 32'h0, 1'b1);
      for (int unsigned k = 0; k < 4; k++) begin
         #1;
         check($sformatf("wdog_cnt%0d", k), csr_rdata, 32'd3 - k);
         check($sformatf("wdog_exp%0d", k), {31'b0, wdog_expired}, (k == 3) ? 32'h1 : 32'h0);
         tick();
      end
      #1;
      check("wdog_hold0", csr_rdata, 32'd0);
      check("wdog_sticky", {31'b0, wdog_expired}, 32'h1);
      clr_csr();
      rd("wdog_mip", 12'h344, 32'h0000_0080);
      check("wdog_irq_take", {31'b0, irq_take}, 32'h1);
      wr(12'h7C2, 32'd5);
      check("wdog_reload_clr", {31'b0, wdog_expired}, 32'h0);
      rd("wdog_reload_cnt", 12'h7C2, 32'd5);
      wr(12'h7C3, 32'd0);
      rd("wdog_freeze_a", 12'h7C2, 32'd4);
      tick(); tick();
      rd("wdog_freeze_b", 12'h7C2, 32'd4);
      wr(12'h7C2, 32'd1);
      wr(12'h7C3, 32'd1);
      tick();
      check("wdog_exp_again", {31'b0, wdog_expired}, 32'h1);
      wr(12'h7C3, 32'd0);
      check("wdog_disable_clr", {31'b0, wdog_expired}, 32'h0);

      // Mailbox sticky status; set beats clear
      mbox_event = 1'b1;
      tick();
      mbox_event = 1'b0;
      rd("mbox_set", 12'h7C5, 32'h1);
      mbox_event = 1'b1;
      wr(12'h7C5, 32'h1);
      mbox_event = 1'b0;
      rd("mbox_set_wins", 12'h7C5, 32'h1);
      wr(12'h7C5, 32'h1);
      rd("mbox_clear", 12'h7C5, 32'h0);

      // Reset mid-countdown
      wr(12'h7C2, 32'd10);
      wr(12'h7C3, 32'd1);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("rstmid_exp", {31'b0, wdog_expired}, 32'h0);
      check("rstmid_mtvec", mtvec_o, 32'h0);
      rd("rstmid_cnt", 12'h7C2, 32'h0);
      tick();
      rst_n = 1'b1;
      for (int unsigned k = 0; k < 12; k++) tick();
      rd("rstmid_cnt_after", 12'h7C2, 32'h0);
      rd("rstmid_ctrl_after", 12'h7C3, 32'h0);
      check("rstmid_exp_after", {31'b0, wdog_expired}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mcu_csr_file.md
MCU_CSR_FILE -- requirements
Module: mcu_csr_file

Interface
REQ-001 SHALL have parameter UID_VAL, default 32'h0000_0001, value returned by CSR 0x7C0.
REQ-002 SHALL have parameter CAPS_VAL, default 32'h0000_0000, value returned by CSR 0x7C1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 csr_valid  in  1  CSR instruction in execute this cycle.
REQ-006 csr_op  in  2  csr_op_e: NONE=0, W=1, S=2, C=3.
REQ-007 csr_addr  in  12  target CSR address.
REQ-008 csr_wdata  in  32  operand: rs1 value or zero-extended uimm, selected upstream.
REQ-009 csr_src_zero  in  1  rs1 index or uimm field is zero.
REQ-010 csr_rdata  out  32  old value of addressed CSR, combinational.
REQ-011 csr_illegal  out  1  access is illegal, combinational.
REQ-012 trap_valid  in  1  take trap this cycle.
REQ-013 trap_pc  in  32  PC of the trap.
REQ-014 trap_cause  in  32  cause of the trap.
REQ-015 trap_tval  in  32  trap value.
REQ-016 mret  in  1  MRET retiring this cycle.
REQ-017 irq_ext  in  1  level external interrupt.
REQ-018 mbox_event  in  1  single-cycle mailbox event pulse.
REQ-019 mtvec_o  out  32  current MTVEC.
REQ-020 mepc_o  out  32  current MEPC.
REQ-021 irq_take  out  1  interrupt should be taken.
REQ-022 wdog_expired  out  1  watchdog expired, sticky.

Function
REQ-023 Implemented addresses: 0x300, 0x304, 0x305, 0x340-0x344, 0x7C0-0x7C6; any other address with csr_valid and op!=NONE SHALL assert csr_illegal, return rdata 0 and change no state.
REQ-024 Write value: W -> wdata; S -> old|wdata; C -> old&~wdata; S/C with csr_src_zero SHALL not write.
REQ-025 Read-only CSRs are MIP, UID and CAPS; a write to one (op W, or S/C without csr_src_zero) SHALL assert csr_illegal with no state change, and a pure read of one SHALL be legal.
REQ-026 Legal writes SHALL commit at the rising edge ending the csr_valid cycle; the new value is visible in csr_rdata the next cycle.
REQ-027 MSTATUS: only MIE (bit 3) and MPIE (bit 7) are stored; all other bits read 0 and ignore writes.
REQ-028 MIE CSR: only MEIE (bit 11) is stored. MIP: MEIP (bit 11) = irq_ext registered one cycle; bit 7 = wdog_expired.
REQ-029 MTVEC and MEPC: bits [1:0] SHALL read 0 regardless of written value. MSCRATCH, MCAUSE, MTVAL, MAILBOX_BASE (0x7C4) and TRACE_CTRL (0x7C6) are full 32-bit RW.
REQ-030 Trap entry (trap_valid): MEPC<=trap_pc&~3, MCAUSE<=trap_cause, MTVAL<=trap_tval, MPIE<=MIE, MIE<=0.
REQ-031 mret: MIE<=MPIE, MPIE<=1.
REQ-032 Same-cycle priority SHALL be trap_valid > mret > CSR write; any lower-priority update is dropped entirely.
REQ-033 irq_take = MSTATUS.MIE & MIE.MEIE & (MIP.MEIP | wdog_expired), combinational.
REQ-034 WDOG (0x7C2) is a 32-bit down-counter; reading returns the live count; writing loads the written value and clears wdog_expired.
REQ-035 WDOG_CTRL (0x7C3) bit 0 = enable, other bits read 0. When enabled and count>0, count SHALL decrement by 1 each cycle; the cycle the count goes 1->0 sets wdog_expired. Count 0 SHALL hold with no wrap. Clearing enable SHALL freeze the count and clear wdog_expired.
REQ-036 MAILBOX_STATUS (0x7C5) bit 0 is sticky-set by mbox_event and cleared by writing 1 to bit 0 (any op value with bit 0 set). If set and clear occur in the same cycle, set wins.

Reset
REQ-037 On rst_n low, all stored CSR bits, the WDOG count, WDOG_CTRL, the mailbox status and the irq_ext sync flop SHALL clear to 0 immediately; hence csr_illegal, irq_take and wdog_expired are 0, and mtvec_o = mepc_o = 0.
REQ-038 Reset asserted mid-countdown SHALL abort the countdown with no expiry.

Verification
REQ-039 Write W 0x305 = 0x8000_0103 -> next cycle mtvec_o = 0x8000_0100; read returns the same.
REQ-040 Set MIE.MEIE and MSTATUS.MIE, then raise irq_ext -> irq_take high 1 cycle later. Then trap_valid with pc=0x1004, cause=0x8000_000B -> MIE=0, MPIE=1, mepc_o=0x1004. Then mret -> MIE=1.
REQ-041 Same cycle: trap_valid plus CSR W to MSTATUS of 0x8 -> MIE=0 (trap wins).
REQ-042 Write WDOG=3, then WDOG_CTRL=1 -> count reads 3,2,1,0 on successive cycles; wdog_expired rises with 0 and stays; writing WDOG=5 clears it.
REQ-043 Write to 0x7C0 (op W) -> csr_illegal=1 and UID unchanged; CSRS 0x7C0 with csr_src_zero -> legal, rdata=UID_VAL; access to 0x123 -> illegal, rdata 0.
REQ-044 Pulse mbox_event while writing 1 to MAILBOX_STATUS in the same cycle -> bit stays 1; a later write of 1 with no event clears it.
